// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding, default sizes and counter-width helper for the DAC serial driver
package dac_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 2;

    typedef enum logic [1:0] {S_GAP, S_IDLE, S_SHIFT} state_t;

    // Bits needed to hold the values 0..n-1, never less than one bit
    function automatic int clog2(input int n);
        int r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: divided serial clock with per-bit start/end strobes
module dac_sclk_gen
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic bit_start,
    output logic bit_end
);

    localparam int DW = clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;
    logic          half;
    logic          last;

    assign last      = div_cnt == DW'(CLK_DIV - 1);
    assign bit_start = en && !half && div_cnt == '0;
    assign bit_end   = en && half && last;

    // High half then low half of each bit; parked high with counters cleared when not shifting
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            div_cnt <= '0;
            half    <= 1'b0;
            sclk    <= 1'b1;
        end else if (clr || !en) begin
            div_cnt <= '0;
            half    <= 1'b0;
            sclk    <= 1'b1;
        end else begin
            div_cnt <= last ? '0 : div_cnt + 1'b1;
            half    <= half ^ last;
            sclk    <= !(half ^ last);
        end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: multi-channel serial DAC driver with valid/ready load and shared SCLK/SYNC
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic                     sclk,
    output logic [NUM_CH-1:0]        dout,
    output logic                     sync,
    output logic                     busy,
    output logic                     done
);

    localparam int BCW = clog2(DATA_W + 1);
    localparam int GCW = clog2(GAP_CYCLES);

    state_t         state;
    logic [BCW-1:0] bit_cnt;
    logic [GCW-1:0] gap_cnt;
    logic           bit_start;
    logic           bit_end;
    logic           shifting;
    logic           accept;
    logic           finish;

    assign shifting = state == S_SHIFT;
    assign accept   = load_valid && load_ready;
    assign finish   = bit_end && bit_cnt == BCW'(DATA_W);

    dac_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .reset    (reset),
        .en       (shifting),
        .clr      (accept),
        .sclk     (sclk),
        .bit_start(bit_start),
        .bit_end  (bit_end)
    );

    // Frame sequencing: hold-off gap, wait for a word, shift until every bit has completed
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_GAP;
            gap_cnt    <= GCW'(GAP_CYCLES - 1);
            bit_cnt    <= '0;
            load_ready <= 1'b0;
            sync       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_GAP:
                    if (gap_cnt == '0) begin
                        state      <= S_IDLE;
                        load_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                S_IDLE:
                    if (accept) begin
                        state      <= S_SHIFT;
                        load_ready <= 1'b0;
                        sync       <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                    end
                S_SHIFT: begin
                    if (bit_start) bit_cnt <= bit_cnt + 1'b1;
                    if (finish) begin
                        state   <= S_GAP;
                        gap_cnt <= GCW'(GAP_CYCLES - 1);
                        sync    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_GAP;
                    gap_cnt    <= GCW'(GAP_CYCLES - 1);
                    load_ready <= 1'b0;
                    sync       <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] sh;
        logic              q;

        assign d       = load_data[k*DATA_W +: DATA_W];
        assign dout[k] = q;

        // First bit goes out with the accept; later bits change only at a bit boundary (sclk rising)
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                sh <= '0;
                q  <= 1'b0;
            end else if (accept) begin
                q  <= MSB_FIRST ? d[DATA_W-1] : d[0];
                sh <= MSB_FIRST ? d << 1 : d >> 1;
            end else if (finish) begin
                q <= 1'b0;
            end else if (bit_end) begin
                q  <= MSB_FIRST ? sh[DATA_W-1] : sh[0];
                sh <= MSB_FIRST ? sh << 1 : sh >> 1;
            end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: three configurations driven with directed and random words, checked by a pin-level frame decoder
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a_data = '0;
    logic [11:0] b_data = '0;
    logic [31:0] c_data = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
    logic        a_ready, b_ready, c_ready;
    logic        a_sclk, b_sclk, c_sclk;
    logic        a_sync, b_sync, c_sync;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [1:0]  a_dout, c_dout;
    logic [0:0]  b_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_tx u_a (
        .clk(clk), .reset(reset), .load_data(a_data), .load_valid(a_valid), .load_ready(a_ready),
        .sclk(a_sclk), .dout(a_dout), .sync(a_sync), .busy(a_busy), .done(a_done)
    );

    dac_spi_tx #(.DATA_W(12), .NUM_CH(1), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .load_data(b_data), .load_valid(b_valid), .load_ready(b_ready),
        .sclk(b_sclk), .dout(b_dout), .sync(b_sync), .busy(b_busy), .done(b_done)
    );

    dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) u_c (
        .clk(clk), .reset(reset), .load_data(c_data), .load_valid(c_valid), .load_ready(c_ready),
        .sclk(c_sclk), .dout(c_dout), .sync(c_sync), .busy(c_busy), .done(c_done)
    );

    logic [2:0] m_sync, m_sclk, m_ready, m_busy, m_done;
    logic [1:0] m_dout [3];

    assign m_sync    = {c_sync, b_sync, a_sync};
    assign m_sclk    = {c_sclk, b_sclk, a_sclk};
    assign m_ready   = {c_ready, b_ready, a_ready};
    assign m_busy    = {c_busy, b_busy, a_busy};
    assign m_done    = {c_done, b_done, a_done};
    assign m_dout[0] = a_dout;
    assign m_dout[1] = {1'b0, b_dout};
    assign m_dout[2] = c_dout;

    int          wd[3]   = '{16, 12, 16};
    bit          msbf[3] = '{1'b1, 1'b0, 1'b1};
    int          low_len[3], high_len[3], nb[3];
    int          last_len[3], last_bits[3], last_gap[3], ready_lat[3];
    int          frames[3]   = '{0, 0, 0};
    int          done_cnt[3] = '{0, 0, 0};
    int          viol[3]     = '{0, 0, 0};
    int          bviol[3]    = '{0, 0, 0};
    int          stuck[3]    = '{0, 0, 0};
    bit          ready_seen[3], last_done[3];
    logic        prev_sync[3], prev_sclk[3];
    logic [1:0]  prev_dout[3];
    logic [31:0] acc[3][2];
    logic [31:0] last_w[3][2];

    // Decode frames from the pins: sample dout at every sclk fall while sync is low
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                low_len[i]    = 0;
                high_len[i]   = 0;
                nb[i]         = 0;
                prev_sync[i]  = 1'b1;
                prev_sclk[i]  = 1'b1;
                prev_dout[i]  = '0;
                ready_seen[i] = 1'b1;
            end else begin
                if (m_done[i]) done_cnt[i]++;
                if (m_busy[i] !== !m_sync[i]) bviol[i]++;
                if (!m_sync[i]) begin
                    if (prev_sync[i]) begin
                        last_gap[i] = high_len[i];
                        low_len[i]  = 0;
                        nb[i]       = 0;
                        acc[i][0]   = '0;
                        acc[i][1]   = '0;
                    end else if (m_dout[i] != prev_dout[i] && !(m_sclk[i] && !prev_sclk[i])) begin
                        viol[i]++;
                    end
                    if (i == 2 && !prev_sync[i] && m_sclk[i] == prev_sclk[i]) stuck[i]++;
                    low_len[i]++;
                    if (prev_sclk[i] && !m_sclk[i]) begin
                        nb[i]++;
                        for (int ch = 0; ch < 2; ch++)
                            acc[i][ch] = msbf[i] ? {acc[i][ch][30:0], m_dout[i][ch]}
                                                 : {m_dout[i][ch], acc[i][ch][31:1]};
                    end
                end else begin
                    if (!prev_sync[i]) begin
                        last_len[i]  = low_len[i];
                        last_bits[i] = nb[i];
                        last_done[i] = m_done[i];
                        for (int ch = 0; ch < 2; ch++)
                            last_w[i][ch] = msbf[i] ? acc[i][ch] : acc[i][ch] >> (32 - wd[i]);
                        frames[i]++;
                        high_len[i]   = 0;
                        ready_seen[i] = 1'b0;
                    end
                    high_len[i]++;
                    if (m_ready[i] && !ready_seen[i]) begin
                        ready_lat[i]  = high_len[i];
                        ready_seen[i] = 1'b1;
                    end
                end
                prev_sync[i] = m_sync[i];
                prev_sclk[i] = m_sclk[i];
                prev_dout[i] = m_dout[i];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] w);
        if (i == 0) begin a_data = w; a_valid = 1'b1; end
        else if (i == 1) begin b_data = w[11:0]; b_valid = 1'b1; end
        else begin c_data = w; c_valid = 1'b1; end
    endtask

    task automatic release_v(input int i);
        if (i == 0) a_valid = 1'b0;
        else if (i == 1) b_valid = 1'b0;
        else c_valid = 1'b0;
    endtask

    task automatic wait_accept(input int i);
        int n = 0;
        while (!m_ready[i] && n < 200) begin
            tick();
            n++;
        end
        check($sformatf("accept_timeout%0d", i), 64'(n < 200), 64'd1);
        @(posedge clk);
        tick();
    endtask

    task automatic wait_frame(input int i);
        int f = frames[i];
        int n = 0;
        while (frames[i] == f && n < 300) begin
            tick();
            n++;
        end
        check($sformatf("frame_timeout%0d", i), 64'(n < 300), 64'd1);
    endtask

    task automatic check_frame(input int i, input logic [31:0] w0, input logic [31:0] w1,
                               input int len, input int bits);
        check($sformatf("len%0d", i), 64'(last_len[i]), 64'(len));
        check($sformatf("falls%0d", i), 64'(last_bits[i]), 64'(bits));
        check($sformatf("ch0_word%0d", i), last_w[i][0], w0);
        check($sformatf("ch1_word%0d", i), last_w[i][1], w1);
        check($sformatf("done_at_rise%0d", i), 64'(last_done[i]), 64'd1);
        check($sformatf("dout_stable%0d", i), 64'(viol[i]), 64'd0);
        check($sformatf("busy_vs_sync%0d", i), 64'(bviol[i]), 64'd0);
    endtask

    initial begin
        logic [31:0] w [4];
        logic [31:0] r;
        int          f0, d0;

        repeat (5) begin
            tick();
            check("rst_pins_a", {m_sync[0], m_sclk[0], m_dout[0], m_ready[0], m_busy[0], m_done[0]}, 7'b1100000);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_edge1_a", m_ready[0], 1'b0);
        check("ready_edge1_c", m_ready[2], 1'b1);
        @(posedge clk); #1;
        check("ready_edge2_a", {m_sync[0], m_sclk[0], m_dout[0], m_ready[0], m_busy[0], m_done[0]}, 7'b1100100);
        check("ready_edge2_b", m_ready[1], 1'b1);
        check("no_done_after_rst", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'd0);
        tick();

        drive(0, {16'h0FF0, 16'hA5C3});
        wait_accept(0);
        release_v(0);
        wait_frame(0);
        check_frame(0, 32'hA5C3, 32'h0FF0, 64, 16);
        check("done_once", 64'(done_cnt[0]), 64'd1);
        repeat (4) tick();
        check("ready_return_a", 64'(ready_lat[0]), 64'd3);

        f0 = frames[0];
        d0 = done_cnt[0];
        for (int n = 0; n < 4; n++) w[n] = $urandom;
        drive(0, w[0]);
        for (int n = 0; n < 4; n++) begin
            wait_accept(0);
            if (n < 3) drive(0, w[n+1]);
            else release_v(0);
            wait_frame(0);
            check_frame(0, {16'h0, w[n][15:0]}, {16'h0, w[n][31:16]}, 64, 16);
            if (n > 0) check("held_gap_a", 64'(last_gap[0]), 64'd3);
        end
        repeat (100) tick();
        check("held_frames_a", 64'(frames[0] - f0), 64'd4);
        check("held_done_a", 64'(done_cnt[0] - d0), 64'd4);

        drive(1, 32'h801);
        wait_accept(1);
        release_v(1);
        wait_frame(1);
        check_frame(1, 32'h801, 32'h0, 48, 12);
        for (int n = 0; n < 2; n++) begin
            r = $urandom & 32'hFFF;
            drive(1, r);
            wait_accept(1);
            release_v(1);
            wait_frame(1);
            check_frame(1, r, 32'h0, 48, 12);
        end

        r = $urandom & 32'hFFFF;
        drive(0, {r[15:0], 16'hFFFF});
        wait_accept(0);
        release_v(0);
        repeat (29) tick();
        check("pre_rst_sync", m_sync[0], 1'b0);
        f0 = frames[0];
        d0 = done_cnt[0];
        reset = 1'b1;
        #1;
        check("mid_rst_pins_a", {m_sync[0], m_sclk[0], m_dout[0], m_ready[0], m_busy[0], m_done[0]}, 7'b1100000);
        tick();
        reset = 1'b0;
        r = $urandom & 32'hFFFF;
        drive(0, {r[15:0], 16'h1234});
        wait_accept(0);
        release_v(0);
        wait_frame(0);
        check("rst_frames_a", 64'(frames[0] - f0), 64'd1);
        check("rst_no_done_a", 64'(done_cnt[0] - d0), 64'd1);
        check_frame(0, 32'h1234, r, 64, 16);

        drive(2, 32'hFFFF_FFFF);
        wait_accept(2);
        drive(2, 32'h0);
        wait_frame(2);
        check_frame(2, 32'hFFFF, 32'hFFFF, 32, 16);
        wait_accept(2);
        release_v(2);
        wait_frame(2);
        check_frame(2, 32'h0, 32'h0, 32, 16);
        check("b2b_gap_c", 64'(last_gap[2]), 64'd2);
        r = $urandom;
        drive(2, r);
        wait_accept(2);
        release_v(2);
        wait_frame(2);
        check_frame(2, {16'h0, r[15:0]}, {16'h0, r[31:16]}, 32, 16);
        check("sclk_toggle_c", 64'(stuck[2]), 64'd0);
        repeat (4) tick();
        check("ready_return_c", 64'(ready_lat[2]), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Parametrised serial DAC driver that replaces the fixed 16-bit single-channel shifter. It accepts one multi-channel sample word through a valid/ready handshake and generates a programmable-rate SCLK, an active-low SYNC frame and one serial data line per channel. All channels share SCLK and SYNC. The block sits between the sample generator / NCO logic and the board DAC pins (dual-channel DAC121-style parts).

Parameters:
DATA_W, 16, bits per channel per frame (4..32)
NUM_CH, 2, number of parallel DOUT lines / DAC channels (1..8)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
GAP_CYCLES, 2, minimum clk cycles SYNC held high between frames and after reset (>=1)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
load_data  in  NUM_CH*DATA_W  sample word; channel k occupies bits [k*DATA_W +: DATA_W]
load_valid  in  1  load_data valid
load_ready  out  1  block can accept a word this cycle
sclk  out  1  serial clock to DAC; idles high
dout  out  NUM_CH  serial data; dout[k] carries channel k
sync  out  1  frame strobe to DAC; active low
busy  out  1  high while a frame is in flight (sync low)
done  out  1  one-cycle pulse at frame completion

Behaviour:
- All outputs registered. Reset values: sync=1, sclk=1, dout=0, load_ready=0, busy=0, done=0.
- States: GAP, IDLE, SHIFT. Reset forces GAP with gap counter = GAP_CYCLES-1.
- GAP: sync=1, sclk=1, dout=0, load_ready=0. Counter decrements each clk; at 0 go to IDLE. GAP therefore lasts exactly GAP_CYCLES cycles. After reset release, load_ready first goes high after GAP_CYCLES rising edges.
- IDLE: load_ready=1. On a cycle with load_valid && load_ready, capture load_data into an internal shadow register and go to SHIFT. load_data is don't-care in every other cycle.
- SHIFT: sync=0, busy=1, load_ready=0. Each bit occupies 2*CLK_DIV clk cycles: CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0. dout changes only at the start of a bit period (coincident with sclk rising), so data is stable across the mid-bit falling edge where the DAC samples.
- First bit (MSB, or LSB if MSB_FIRST=0) appears on dout in the first SHIFT cycle, i.e. one clk after acceptance.
- Bit counter width $clog2(DATA_W+1). After bit DATA_W-1 completes its low half, go to GAP: sync=1, sclk=1, dout=0, done=1 for exactly that first GAP cycle.
- Frame length: sync low for exactly DATA_W*2*CLK_DIV clk cycles.
- Minimum spacing between acceptances: 1 + DATA_W*2*CLK_DIV + GAP_CYCLES cycles. With load_valid held high, SYNC stays high GAP_CYCLES+1 cycles between frames (GAP plus the accept cycle in IDLE).
- load_valid while not ready: ignored; the producer must hold the word (standard valid/ready).
- Reset mid-frame: outputs return to reset values immediately (asynchronously). The frame is abandoned with no done pulse, then the normal GAP sequence runs.
- No partial frames: SYNC never rises before DATA_W bits complete except on reset.
- CLK_DIV=1 is legal: sclk toggles every clk.

Decomposition:
- Shared package/include dac_pkg: state encoding (GAP, IDLE, SHIFT), default DATA_W / NUM_CH constants, and a clog2 function for the counter widths.
- One sub-module, dac_sclk_gen. It holds the CLK_DIV counter and produces a registered sclk plus one-cycle bit_start / bit_end strobes, with enable and synchronous clear. The top module holds the FSM, shadow shift registers (one per channel, generate loop), and bit/gap counters.

Test Plan:
- Defaults, reset 5 cycles then release -> sync=1, sclk=1, dout=0 throughout. load_ready rises exactly 2 edges after release; busy=0, no done pulse.
- Defaults, one word ch0=16'hA5C3, ch1=16'h0FF0 -> sync low exactly 64 cycles, 16 sclk falling edges. Sampling at falls gives dout[0]=A5C3 and dout[1]=0FF0 MSB first; done pulses once as sync rises; load_ready returns after 2 cycles.
- load_valid held high with 4 distinct words -> 4 frames, each 64 cycles low. Sync high exactly 3 cycles between frames; each word is taken exactly once, in order.
- MSB_FIRST=0, DATA_W=12, NUM_CH=1, word 12'h801 -> first sampled bit 1, then ten 0s, last bit 1; sync low 48 cycles.
- Defaults, reset asserted during bit 7 of frame carrying 16'hFFFF -> sync=1, sclk=1, dout=0 in the same cycle. No done pulse; next accepted word 16'h1234 is transmitted intact.
- CLK_DIV=1, GAP_CYCLES=1, words 16'hFFFF then 16'h0000 back-to-back -> sclk toggles every clk, sync low 32 cycles each, high 2 cycles between frames, all sampled bits correct.
